// File: rtl/jpeg_stream_sequencer.sv
// JPEG frame sequencer: SOI, ROM header, drained entropy bytes, EOI,
// presented as one registered valid/ready byte stream.
module jpeg_stream_sequencer #(
    parameter int HDR_LEN    = 607,
    parameter int HDR_AW     = 10,
    parameter int DRAIN_IDLE = 4,
    parameter int FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              es_ready,
    input  logic [7:0]        es_rdata,
    output logic              es_dequeue,
    output logic [HDR_AW-1:0] hdr_addr,
    input  logic [7:0]        hdr_data,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE, SOI0, SOI1, HDR_ADDR, HDR_DATA, SCAN, EOI0, EOI1
    } state_t;

    localparam int IW = $clog2(DRAIN_IDLE + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(DRAIN_IDLE);
    localparam logic [HDR_AW-1:0] HDR_LAST =
        (HDR_LEN > 0) ? HDR_AW'(HDR_LEN - 1) : '0;

    state_t            state, state_n;
    logic              out_valid_n;
    logic [7:0]        out_data_n;
    logic [HDR_AW-1:0] hdr_addr_n;
    logic              end_latch, end_latch_n;
    logic [IW-1:0]     idle_cnt, idle_cnt_n;
    logic [FCNT_W-1:0] frame_cnt_n;
    logic              adv;
    logic              load;
    logic [7:0]        ld_data;

    assign adv  = !out_valid || out_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            hdr_addr  <= '0;
            end_latch <= 1'b0;
            idle_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            hdr_addr  <= hdr_addr_n;
            end_latch <= end_latch_n;
            idle_cnt  <= idle_cnt_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        hdr_addr_n  = hdr_addr;
        end_latch_n = end_latch;
        idle_cnt_n  = '0;
        frame_cnt_n = frame_cnt;
        es_dequeue  = 1'b0;
        load        = 1'b0;
        ld_data     = 8'h00;

        if (frame_end && state != IDLE && state != EOI0 && state != EOI1)
            end_latch_n = 1'b1;

        case (state)
            IDLE: begin
                if (frame_start)
                    state_n = SOI0;
            end
            SOI0: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = 8'hFF;
                    state_n = SOI1;
                end
            end
            SOI1: begin
                if (adv) begin
                    load       = 1'b1;
                    ld_data    = 8'hD8;
                    hdr_addr_n = '0;
                    state_n    = (HDR_LEN == 0) ? SCAN : HDR_ADDR;
                end
            end
            HDR_ADDR: begin
                state_n = HDR_DATA;
            end
            HDR_DATA: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = hdr_data;
                    if (hdr_addr == HDR_LAST) begin
                        state_n = SCAN;
                    end else begin
                        hdr_addr_n = hdr_addr + HDR_AW'(1);
                        state_n    = HDR_ADDR;
                    end
                end
            end
            SCAN: begin
                if (es_ready && adv) begin
                    es_dequeue = 1'b1;
                    load       = 1'b1;
                    ld_data    = es_rdata;
                end
                // Queue counts as empty only after a run of idle cycles
                if (!es_ready && end_latch)
                    idle_cnt_n = (idle_cnt == IDLE_MAX) ?
                                 idle_cnt : idle_cnt + IW'(1);
                if (end_latch && idle_cnt == IDLE_MAX && !es_ready)
                    state_n = EOI0;
            end
            EOI0: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = 8'hFF;
                    state_n = EOI1;
                end
            end
            EOI1: begin
                if (adv) begin
                    load        = 1'b1;
                    ld_data     = 8'hD9;
                    frame_cnt_n = frame_cnt + FCNT_W'(1);
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (adv) begin
            out_valid_n = load;
            if (load)
                out_data_n = ld_data;
        end

        if (state_n == IDLE)
            end_latch_n = 1'b0;
    end

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Directed bench: frames through a 3-byte-header instance and a
// header-less 2-bit-counter instance sharing one byte queue model.
module tb_jpeg_stream_sequencer;

    localparam int DRAIN_IDLE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, out_ready, es_en, bp, held;
    logic fs_a, fe_a, fs_b, fe_b;
    int   hold;

    logic [7:0] qmem [64];
    logic [5:0] qwr = '0;
    logic [5:0] qrd = '0;
    logic       es_ready;
    logic [7:0] es_rdata;
    assign es_ready = es_en && (qwr != qrd);
    assign es_rdata = qmem[qrd];

    logic       es_dequeue_a, out_valid_a, busy_a;
    logic [1:0] hdr_addr_a;
    logic [7:0] hdr_data_a, out_data_a;
    logic [15:0] frame_cnt_a;

    logic       es_dequeue_b, out_valid_b, busy_b;
    logic [1:0] hdr_addr_b;
    logic [7:0] out_data_b;
    logic [1:0] frame_cnt_b;

    jpeg_stream_sequencer #(
        .HDR_LEN(3), .HDR_AW(2), .DRAIN_IDLE(DRAIN_IDLE), .FCNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst),
        .frame_start(fs_a), .frame_end(fe_a),
        .es_ready(es_ready), .es_rdata(es_rdata),
        .es_dequeue(es_dequeue_a),
        .hdr_addr(hdr_addr_a), .hdr_data(hdr_data_a),
        .out_valid(out_valid_a), .out_data(out_data_a),
        .out_ready(out_ready),
        .busy(busy_a), .frame_cnt(frame_cnt_a)
    );

    jpeg_stream_sequencer #(
        .HDR_LEN(0), .HDR_AW(2), .DRAIN_IDLE(DRAIN_IDLE), .FCNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst),
        .frame_start(fs_b), .frame_end(fe_b),
        .es_ready(es_ready), .es_rdata(es_rdata),
        .es_dequeue(es_dequeue_b),
        .hdr_addr(hdr_addr_b), .hdr_data(8'h00),
        .out_valid(out_valid_b), .out_data(out_data_b),
        .out_ready(out_ready),
        .busy(busy_b), .frame_cnt(frame_cnt_b)
    );

    function automatic logic [7:0] rom(input logic [1:0] a);
        case (a)
            2'd0:    return 8'hE0;
            2'd1:    return 8'h00;
            2'd2:    return 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) hdr_data_a <= rom(hdr_addr_a);

    always @(posedge clk)
        if (es_dequeue_a || es_dequeue_b) qrd <= qrd + 6'd1;

    logic [7:0] cap [512];
    int         capcyc [512];
    int         ncap = 0;
    int         cyc = 0;
    always @(posedge clk) begin
        cyc++;
        if (ncap < 512) begin
            if (out_valid_a && out_ready) begin
                cap[ncap] = out_data_a; capcyc[ncap] = cyc; ncap++;
            end else if (out_valid_b && out_ready) begin
                cap[ncap] = out_data_b; capcyc[ncap] = cyc; ncap++;
            end
        end
    end

    int         mon_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    always @(posedge clk) begin
        if (prev_stall && (!out_valid_a || out_data_a !== prev_d))
            mon_err++;
        if (es_dequeue_a && out_valid_a && !out_ready) mon_err++;
        if ((es_dequeue_a || es_dequeue_b) && !es_ready) mon_err++;
        prev_stall = out_valid_a && !out_ready && rst;
        prev_d     = out_data_a;
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bp) begin
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = !out_ready;
                end
            end
        end
    endtask

    task automatic push(input logic [7:0] b);
        qmem[qwr] = b;
        qwr = qwr + 6'd1;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (qrd != qwr && k < 300) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(qrd == qwr), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input bit b);
        int k = 0;
        while ((b ? busy_b : busy_a) && k < 400) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(b ? busy_b : busy_a), 32'd0);
    endtask

    task automatic check_seq(input string tag, input int base);
        chk({tag, "_len"}, 32'(ncap - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(cap[base + i]),
                32'(exp_q[i]));
    endtask

    task automatic pulse_a(input bit start);
        if (start) fs_a = 1'b1; else fe_a = 1'b1;
        tick(1);
        fs_a = 1'b0;
        fe_a = 1'b0;
    endtask

    initial begin
        int base;
        int gap;
        logic [7:0] sb;
        rst = 1'b0; out_ready = 1'b1; es_en = 1'b1;
        bp = 1'b0; held = 1'b0; hold = 0;
        fs_a = 1'b0; fe_a = 1'b0; fs_b = 1'b0; fe_b = 1'b0;
        tick(2);
        chk("rst_valid", 32'(out_valid_a), 32'd0);
        chk("rst_data", 32'(out_data_a), 32'h00);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt_a), 32'd0);
        chk("rst_addr", 32'(hdr_addr_a), 32'd0);
        chk("rst_deq", 32'(es_dequeue_a), 32'd0);
        chk("rst_fcnt_b", 32'(frame_cnt_b), 32'd0);
        rst = 1'b1;
        tick(1);

        // basic frame
        push(8'h12); push(8'hFF); push(8'h00); push(8'h34);
        base = ncap;
        pulse_a(1'b1);
        chk("lat_busy", 32'(busy_a), 32'd1);
        chk("lat_v0", 32'(out_valid_a), 32'd0);
        tick(1);
        chk("lat_v1", 32'(out_valid_a), 32'd1);
        chk("lat_soi", 32'(out_data_a), 32'hFF);
        wait_drain("basic_drain");
        pulse_a(1'b0);
        wait_idle("basic_idle", 1'b0);
        tick(2);
        exp_q = {8'hFF, 8'hD8, 8'hE0, 8'h00, 8'h10,
                 8'h12, 8'hFF, 8'h00, 8'h34, 8'hFF, 8'hD9};
        check_seq("basic", base);
        chk("basic_fcnt", 32'(frame_cnt_a), 32'd1);
        chk("basic_busy", 32'(busy_a), 32'd0);

        // backpressure
        push(8'h12); push(8'hFF); push(8'h00); push(8'h34);
        base = ncap;
        bp = 1'b1;
        held = 1'b0;
        pulse_a(1'b1);
        for (int k = 0; k < 300 && qrd != qwr; k++) begin
            if (hdr_addr_a == 2'd1 && !held) begin
                hold = 5;
                held = 1'b1;
            end
            tick(1);
        end
        chk("bp_drain", 32'(qrd == qwr), 32'd1);
        pulse_a(1'b0);
        wait_idle("bp_idle", 1'b0);
        tick(4);
        bp = 1'b0;
        out_ready = 1'b1;
        tick(2);
        check_seq("bp", base);
        chk("bp_held", 32'(held), 32'd1);
        chk("bp_fcnt", 32'(frame_cnt_a), 32'd2);

        // early end, queue empty until SCAN is reached
        es_en = 1'b0;
        base = ncap;
        pulse_a(1'b1);
        pulse_a(1'b0);
        tick(8);
        push(8'hAB); push(8'hCD);
        es_en = 1'b1;
        wait_idle("early_idle", 1'b0);
        tick(2);
        exp_q = {8'hFF, 8'hD8, 8'hE0, 8'h00, 8'h10,
                 8'hAB, 8'hCD, 8'hFF, 8'hD9};
        check_seq("early", base);
        gap = capcyc[base + 7] - capcyc[base + 6];
        chk("early_gap", 32'(gap >= DRAIN_IDLE + 2), 32'd1);
        chk("early_fcnt", 32'(frame_cnt_a), 32'd3);

        // ignored pulses
        es_en = 1'b0;
        push(8'h5A); push(8'hA5);
        pulse_a(1'b0);
        base = ncap;
        pulse_a(1'b1);
        tick(12);
        pulse_a(1'b1);
        tick(4);
        es_en = 1'b1;
        wait_drain("ign_drain");
        pulse_a(1'b0);
        wait_idle("ign_idle", 1'b0);
        tick(2);
        exp_q = {8'hFF, 8'hD8, 8'hE0, 8'h00, 8'h10,
                 8'h5A, 8'hA5, 8'hFF, 8'hD9};
        check_seq("ign", base);
        chk("ign_fcnt", 32'(frame_cnt_a), 32'd4);
        base = ncap;
        tick(6);
        chk("ign_no_soi", 32'(ncap - base), 32'd0);
        chk("ign_busy", 32'(busy_a), 32'd0);

        // reset mid-header
        pulse_a(1'b1);
        tick(4);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("mrst_valid", 32'(out_valid_a), 32'd0);
        chk("mrst_fcnt", 32'(frame_cnt_a), 32'd0);
        chk("mrst_busy", 32'(busy_a), 32'd0);
        push(8'h77);
        base = ncap;
        pulse_a(1'b1);
        wait_drain("mrst_drain");
        pulse_a(1'b0);
        wait_idle("mrst_idle", 1'b0);
        tick(2);
        exp_q = {8'hFF, 8'hD8, 8'hE0, 8'h00, 8'h10,
                 8'h77, 8'hFF, 8'hD9};
        check_seq("mrst", base);
        chk("mrst_fcnt1", 32'(frame_cnt_a), 32'd1);

        // zero-length header and counter wrap
        for (int f = 0; f < 5; f++) begin
            sb = 8'h30 + 8'(f);
            push(sb);
            base = ncap;
            fs_b = 1'b1;
            tick(1);
            fs_b = 1'b0;
            wait_drain("b_drain");
            fe_b = 1'b1;
            tick(1);
            fe_b = 1'b0;
            wait_idle("b_idle", 1'b1);
            tick(2);
            exp_q = {8'hFF, 8'hD8, sb, 8'hFF, 8'hD9};
            check_seq($sformatf("b%0d", f), base);
            chk($sformatf("b%0d_fcnt", f), 32'(frame_cnt_b),
                32'((f + 1) % 4));
        end

        chk("monitor", 32'(mon_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
